// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pkg                                                                   |
// | Segment bit order, glyph constants and blank code for the scan driver.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Bit positions inside seg_t (bit6..bit0 = g,f,e,d,c,b,a), active low
    localparam int c_seg_a = 0;
    localparam int c_seg_b = 1;
    localparam int c_seg_c = 2;
    localparam int c_seg_d = 3;
    localparam int c_seg_e = 4;
    localparam int c_seg_f = 5;
    localparam int c_seg_g = 6;

    localparam seg_t c_seg_blank = 7'h7F;

    localparam seg_t c_glyph_0 = 7'b1000000;
    localparam seg_t c_glyph_1 = 7'b1111001;
    localparam seg_t c_glyph_2 = 7'b0100100;
    localparam seg_t c_glyph_3 = 7'b0110000;
    localparam seg_t c_glyph_4 = 7'b0011001;
    localparam seg_t c_glyph_5 = 7'b0010010;
    localparam seg_t c_glyph_6 = 7'b0000010;
    localparam seg_t c_glyph_7 = 7'b1111000;
    localparam seg_t c_glyph_8 = 7'b0000000;
    localparam seg_t c_glyph_9 = 7'b0010000;
    localparam seg_t c_glyph_a = 7'b0001000;
    localparam seg_t c_glyph_b = 7'b0000011;
    localparam seg_t c_glyph_c = 7'b1000110;
    localparam seg_t c_glyph_d = 7'b0100001;
    localparam seg_t c_glyph_e = 7'b0000110;
    localparam seg_t c_glyph_f = 7'b0001110;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_glyph                                                                 |
// | Combinational nibble to active-low seven-segment glyph decode.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_glyph #(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    localparam bit c_hex = (HEX_MODE != 0);

    always_comb begin
        seg = c_seg_blank;
        case (nibble)
            4'h0: seg = c_glyph_0;
            4'h1: seg = c_glyph_1;
            4'h2: seg = c_glyph_2;
            4'h3: seg = c_glyph_3;
            4'h4: seg = c_glyph_4;
            4'h5: seg = c_glyph_5;
            4'h6: seg = c_glyph_6;
            4'h7: seg = c_glyph_7;
            4'h8: seg = c_glyph_8;
            4'h9: seg = c_glyph_9;
            4'ha: seg = c_hex ? c_glyph_a : c_seg_blank;
            4'hb: seg = c_hex ? c_glyph_b : c_seg_blank;
            4'hc: seg = c_hex ? c_glyph_c : c_seg_blank;
            4'hd: seg = c_hex ? c_glyph_d : c_seg_blank;
            4'he: seg = c_hex ? c_glyph_e : c_seg_blank;
            4'hf: seg = c_hex ? c_glyph_f : c_seg_blank;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_driver                                                           |
// | Multiplexed 7-segment scanner with frame-synchronous load, LZ blanking,    |
// | per-digit blink and dead time between digit slots.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int HEX_MODE     = 0,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blink_in,
    input  logic                      load,
    input  logic                      lz_blank,
    input  logic                      en,
    output logic [6:0]                seg_n,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_start
);
    import seg7_pkg::*;

    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_pre_w = $clog2(SCAN_DIV);
    localparam int c_frm_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);
    localparam logic [c_frm_w-1:0] c_frm_last = c_frm_w'(BLINK_FRAMES - 1);

    logic [c_pre_w-1:0]      r_pre;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_frm_w-1:0]      r_frm;
    logic                    r_phase;
    logic [4*NUM_DIGITS-1:0] r_disp_dig;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_disp_blink;
    logic [4*NUM_DIGITS-1:0] r_pend_dig;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blink;
    logic                    r_pend;

    logic                    w_tc;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_blink_sel;
    logic                    w_lz_sel;
    logic [6:0]              w_glyph;
    logic                    w_blink_off;
    logic                    w_fs_next;

    assign w_tc        = en && (r_pre == c_pre_last);
    assign w_frame_end = w_tc && (r_idx == c_idx_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_frm   <= '0;
            r_phase <= 1'b0;
        end else if (en) begin
            if (w_tc) begin
                r_pre <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            if (w_frame_end) begin
                if (r_frm == c_frm_last) begin
                    r_frm   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_frm <= r_frm + 1'b1;
                end
            end
        end
    end

    // Transfer uses the buffer as it stood before this edge; a coincident load stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_dig   <= '0;
            r_disp_dp    <= '0;
            r_disp_blink <= '0;
            r_pend_dig   <= '0;
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_pend       <= 1'b0;
        end else begin
            if (w_frame_end && r_pend) begin
                r_disp_dig   <= r_pend_dig;
                r_disp_dp    <= r_pend_dp;
                r_disp_blink <= r_pend_blink;
            end
            if (load) begin
                r_pend_dig   <= digits_in;
                r_pend_dp    <= dp_in;
                r_pend_blink <= blink_in;
                r_pend       <= 1'b1;
            end else if (w_frame_end) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Zero run from the most significant digit down; digit 0 is never part of it
    always_comb begin
        w_lz       = '0;
        w_zero_run = lz_blank;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (r_disp_dig[4*k +: 4] == 4'h0);
            w_lz[k]    = w_zero_run;
        end
    end

    always_comb begin
        w_onehot    = '0;
        w_nib       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blink_sel = 1'b0;
        w_lz_sel    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_onehot[k] = 1'b1;
                w_nib       = r_disp_dig[4*k +: 4];
                w_dp_sel    = r_disp_dp[k];
                w_blink_sel = r_disp_blink[k];
                w_lz_sel    = w_lz[k];
            end
        end
    end

    seg7_glyph #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph (
        .nibble (w_nib),
        .seg    (w_glyph)
    );

    assign w_blink_off = w_blink_sel && r_phase;
    assign w_fs_next   = en && (r_pre == '0) && (r_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n       <= c_seg_blank;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else if (!en) begin
            seg_n       <= c_seg_blank;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            seg_n       <= (w_lz_sel || w_blink_off) ? c_seg_blank : w_glyph;
            dp_n        <= ~(w_dp_sel && !w_blink_off);
            an_n        <= (r_pre == '0) ? '1 : ~w_onehot;
            frame_start <= w_fs_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal minimum 2.
REQ-003 Parameter HEX_MODE, default 0: 0 = codes 10..15 blank; 1 = codes 10..15 shown as A,b,C,d,E,F.
REQ-004 Parameter BLINK_FRAMES, default 64: frames per blink half-period; legal minimum 1.
REQ-005 clk  in  1  sole clock.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 digits_in  in  4*NUM_DIGITS  BCD/hex nibbles; nibble k drives digit k; digit 0 is least significant.
REQ-008 dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-009 blink_in  in  NUM_DIGITS  blink enable per digit.
REQ-010 load  in  1  capture strobe for digits_in, dp_in and blink_in.
REQ-011 lz_blank  in  1  leading-zero blanking enable.
REQ-012 en  in  1  display enable.
REQ-013 seg_n  out  7  active-low segments, bit6..bit0 = g,f,e,d,c,b,a.
REQ-014 dp_n  out  1  active-low decimal point.
REQ-015 an_n  out  NUM_DIGITS  active-low digit select, one-hot-low.
REQ-016 frame_start  out  1  one-cycle pulse at the start of each digit-0 slot.

Function
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-018 All outputs SHALL be registered; an output change SHALL appear one clk after the index or prescaler change that causes it.
REQ-019 Dead time: while prescaler = 0, an_n SHALL be all ones, to prevent ghosting.
REQ-020 load = 1 SHALL copy the inputs into a pending buffer and set a pending flag; a later load before transfer overwrites the buffer (latest wins).
REQ-021 At a frame boundary (terminal count with index = NUM_DIGITS-1), if the pending flag is set, the pending buffer SHALL move to the display registers and the flag SHALL clear; digit data never changes mid-frame.
REQ-022 load on the same cycle as a frame boundary: the buffer transferred SHALL be the one held before that cycle; the new data SHALL stay pending for the next boundary.
REQ-023 Glyphs 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-024 With HEX_MODE=1, codes A..F SHALL use glyphs 0001000, 0000011, 1000110, 0100001, 0000110, 0001110; with HEX_MODE=0, codes 10..15 SHALL give 1111111.
REQ-025 Leading-zero blanking: with lz_blank = 1, digits from NUM_DIGITS-1 downward whose code is 0 SHALL be blanked until the first non-zero digit; digit 0 is never blanked; dp still shows on a blanked digit.
REQ-026 A frame counter SHALL toggle blink_phase every BLINK_FRAMES frames; while blink_phase = 1, digits with their blink bit set SHALL output seg_n = 7F and dp_n = 1.
REQ-027 en = 0 SHALL force seg_n = 7F, dp_n = 1 and an_n all ones, and SHALL hold the prescaler, index and frame counter; load SHALL still be accepted.
REQ-028 frame_start SHALL pulse one clk after the index wraps to 0, and SHALL not pulse while en = 0.

Reset
REQ-029 When rst_n = 0, the block SHALL set seg_n = 7F, dp_n = 1, an_n all ones and frame_start = 0.
REQ-030 When rst_n = 0, the block SHALL clear the prescaler, index, frame counter, blink_phase, display registers, pending buffer and pending flag.
REQ-031 Reset asserted mid-frame SHALL take effect immediately and discard pending data; after release, scanning SHALL restart at digit 0 with prescaler 0.

Structure
REQ-032 Package seg7_pkg SHALL hold the glyph constants, the blank constant 7F and the segment bit-order definition.
REQ-033 Sub-module seg7_glyph SHALL implement the combinational nibble-to-glyph decode, with HEX_MODE as its parameter.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-034 Reset release, en = 1 -> an_n sequence 1111 (dead time), then 1110, 1101, 1011, 0111, with 3 selected cycles per digit; frame_start pulses every 16 clk.
REQ-035 load digits_in = 16'h0305 mid-frame with lz_blank = 1 -> display unchanged until the boundary; then digit3 = 7F, digit2 = 0110000, digit1 = 1000000, digit0 = 0010010.
REQ-036 HEX_MODE = 0 with digits_in = 16'hAF00 and lz_blank = 0 -> digits 3 and 2 show 7F; with HEX_MODE = 1 -> 0001000 and 0001110.
REQ-037 blink_in = 4'b0001, dp_in = 4'b0001 -> digit0 seg_n and dp_n are lit for frames 0-1 and blank for frames 2-3, repeating; other digits are unaffected.
REQ-038 load 16'h1111, then load 16'h2222 on the boundary cycle -> next frame shows 1111 and the following frame shows 2222; en = 0 for 10 cycles -> outputs blank and scan position resumes unchanged.
REQ-039 rst_n asserted mid-frame with data pending -> outputs blank immediately, and after release the display shows 0 with no pending transfer.
